// File: rtl/upc_seq_pkg.sv
// Shared definitions for the microprogram address sequencer:
// next-address op encodings and the run/halt state type.
package upc_seq_pkg;

   localparam logic [2:0] OP_NEXT  = 3'd0;
   localparam logic [2:0] OP_MAP   = 3'd1;
   localparam logic [2:0] OP_JUMP  = 3'd2;
   localparam logic [2:0] OP_CJUMP = 3'd3;
   localparam logic [2:0] OP_CALL  = 3'd4;
   localparam logic [2:0] OP_RET   = 3'd5;
   localparam logic [2:0] OP_HALT  = 3'd6;
   localparam logic [2:0] OP_FETCH = 3'd7;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } seq_state_e;

endpackage

// File: rtl/upc_stack.sv
// Micro-subroutine return-address LIFO with occupancy counter and synchronous clear.
// Storage is not reset; only the occupancy decides which entries are meaningful.
module upc_stack #(
   parameter int AW    = 8,
   parameter int DEPTH = 4,
   localparam int SPW  = $clog2(DEPTH + 1),
   localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           clr,
   input  logic           push,
   input  logic           pop,
   input  logic [AW-1:0]  din,
   output logic [AW-1:0]  top,
   output logic           full,
   output logic           empty,
   output logic [SPW-1:0] sp
);

   localparam logic [SPW-1:0] SP_ONE   = {{(SPW-1){1'b0}}, 1'b1};
   localparam logic [SPW-1:0] SP_ZERO  = {SPW{1'b0}};
   localparam logic [SPW-1:0] SP_DEPTH = SPW'(DEPTH);

   logic [AW-1:0]  mem_r [DEPTH];
   logic [SPW-1:0] sp_r;
   logic [SPW-1:0] sp_dec_s;
   logic [IW-1:0]  wr_idx_s;
   logic [IW-1:0]  rd_idx_s;
   logic           full_s;
   logic           empty_s;

   assign full_s   = (sp_r == SP_DEPTH);
   assign empty_s  = (sp_r == SP_ZERO);
   assign sp_dec_s = sp_r - SP_ONE;
   assign wr_idx_s = sp_r[IW-1:0];
   assign rd_idx_s = sp_dec_s[IW-1:0];

   assign top   = mem_r[rd_idx_s];
   assign full  = full_s;
   assign empty = empty_s;
   assign sp    = sp_r;

   // Entry storage: write the next free slot on an accepted push.
   always_ff @(posedge clk) begin
      if (push && !full_s) begin
         mem_r[wr_idx_s] <= din;
      end
   end

   // Occupancy counter; push wins if both are ever requested together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sp_r <= SP_ZERO;
      end else if (clr) begin
         sp_r <= SP_ZERO;
      end else if (push && !full_s) begin
         sp_r <= sp_r + SP_ONE;
      end else if (pop && !empty_s) begin
         sp_r <= sp_dec_s;
      end else begin
         sp_r <= sp_r;
      end
   end

endmodule

// File: rtl/upc_sequencer.sv
// Microprogram address sequencer: produces the control-store address each clock
// from the microinstruction next-address mode, with call/return and halt handling.
module upc_sequencer
   import upc_seq_pkg::*;
#(
   parameter int              AW         = 8,
   parameter int              SW         = 8,
   parameter int              DEPTH      = 4,
   parameter logic [AW-1:0]   FETCH_ADDR = {AW{1'b0}},
   localparam int             CSW        = (SW > 1) ? $clog2(SW) : 1,
   localparam int             SPW        = $clog2(DEPTH + 1)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   input  logic           restart,
   input  logic [2:0]     op,
   input  logic [CSW-1:0] cond_sel,
   input  logic           cond_pol,
   input  logic [AW-1:0]  jump_addr,
   input  logic [AW-1:0]  map_addr,
   input  logic [SW-1:0]  status,
   output logic [AW-1:0]  upc,
   output logic           halted,
   output logic           stack_ovf,
   output logic           stack_unf,
   output logic [SPW-1:0] sp
);

   localparam logic [AW-1:0] UPC_ONE = {{(AW-1){1'b0}}, 1'b1};

   seq_state_e    state_r;
   logic [AW-1:0] upc_r;
   logic          ovf_r;
   logic          unf_r;

   logic [AW-1:0] upc_inc_s;
   logic [AW-1:0] stack_top_s;
   logic          stack_full_s;
   logic          stack_empty_s;
   logic          active_s;
   logic          push_s;
   logic          pop_s;
   logic          cond_s;

   assign upc_inc_s = upc_r + UPC_ONE;
   assign active_s  = (state_r == RUN) && en && !restart;
   assign push_s    = active_s && (op == OP_CALL) && !stack_full_s;
   assign pop_s     = active_s && (op == OP_RET) && !stack_empty_s;

   // Branch condition; an out-of-range flag select never branches.
   always_comb begin
      cond_s = 1'b0;
      if (int'(cond_sel) < SW) begin
         cond_s = status[cond_sel] ^ cond_pol;
      end else begin
         cond_s = 1'b0;
      end
   end

   upc_stack #(
      .AW    (AW),
      .DEPTH (DEPTH)
   ) u_stack (
      .clk   (clk),
      .rst   (rst),
      .clr   (restart),
      .push  (push_s),
      .pop   (pop_s),
      .din   (upc_inc_s),
      .top   (stack_top_s),
      .full  (stack_full_s),
      .empty (stack_empty_s),
      .sp    (sp)
   );

   // Sequencer FSM: restart, then halt hold, then enable hold, then op decode.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= RUN;
         upc_r   <= FETCH_ADDR;
         ovf_r   <= 1'b0;
         unf_r   <= 1'b0;
      end else if (restart) begin
         state_r <= RUN;
         upc_r   <= FETCH_ADDR;
         ovf_r   <= 1'b0;
         unf_r   <= 1'b0;
      end else if (state_r == HALT) begin
         upc_r <= upc_r;
      end else if (en) begin
         case (op)
            OP_NEXT:  upc_r <= upc_inc_s;
            OP_MAP:   upc_r <= map_addr;
            OP_JUMP:  upc_r <= jump_addr;
            OP_CJUMP: upc_r <= cond_s ? jump_addr : upc_inc_s;
            OP_CALL: begin
               if (stack_full_s) begin
                  ovf_r   <= 1'b1;
                  state_r <= HALT;
               end else begin
                  upc_r <= jump_addr;
               end
            end
            OP_RET: begin
               if (stack_empty_s) begin
                  unf_r   <= 1'b1;
                  state_r <= HALT;
               end else begin
                  upc_r <= stack_top_s;
               end
            end
            OP_HALT:  state_r <= HALT;
            OP_FETCH: upc_r <= FETCH_ADDR;
            default:  upc_r <= upc_r;
         endcase
      end else begin
         upc_r <= upc_r;
      end
   end

   assign upc       = upc_r;
   assign halted    = (state_r == HALT);
   assign stack_ovf = ovf_r;
   assign stack_unf = unf_r;

endmodule

// File: tb/tb_upc_sequencer.sv
// Directed vector bench for upc_sequencer (AW=8, SW=8, DEPTH=4, FETCH_ADDR=0).
module tb_upc_sequencer;
   import upc_seq_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       restart;
   logic [2:0] op;
   logic [2:0] cond_sel;
   logic       cond_pol;
   logic [7:0] jump_addr;
   logic [7:0] map_addr;
   logic [7:0] status;
   logic [7:0] upc;
   logic       halted;
   logic       stack_ovf;
   logic       stack_unf;
   logic [2:0] sp;

   int checks = 0;
   int passed = 0;

   typedef struct packed {
      logic       rs;
      logic       en;
      logic [2:0] op;
      logic [2:0] sel;
      logic       pol;
      logic [7:0] ja;
      logic [7:0] ma;
      logic [7:0] st;
      logic [7:0] e_upc;
      logic [2:0] e_sp;
      logic       e_halt;
      logic       e_ovf;
      logic       e_unf;
   } vec_t;

   vec_t vecs[$];

   upc_sequencer #(
      .AW(8), .SW(8), .DEPTH(4), .FETCH_ADDR(8'h00)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .restart(restart), .op(op),
      .cond_sel(cond_sel), .cond_pol(cond_pol), .jump_addr(jump_addr),
      .map_addr(map_addr), .status(status), .upc(upc), .halted(halted),
      .stack_ovf(stack_ovf), .stack_unf(stack_unf), .sp(sp)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic rs_i, input logic en_i, input logic [2:0] op_i,
                               input logic [2:0] sel_i, input logic pol_i,
                               input logic [7:0] ja_i, input logic [7:0] ma_i,
                               input logic [7:0] st_i, input logic [7:0] eu_i,
                               input logic [2:0] esp_i, input logic eh_i,
                               input logic eo_i, input logic eun_i);
      vec_t v;
      v = '{rs_i, en_i, op_i, sel_i, pol_i, ja_i, ma_i, st_i, eu_i, esp_i, eh_i, eo_i, eun_i};
      return v;
   endfunction

   task automatic check(input string name, input logic [7:0] e_upc, input logic [2:0] e_sp,
                        input logic e_h, input logic e_o, input logic e_u);
      checks++;
      if ({upc, sp, halted, stack_ovf, stack_unf} === {e_upc, e_sp, e_h, e_o, e_u}) begin
         passed++;
      end else begin
         $display("FAIL %s: got upc=%h sp=%0d halted=%b ovf=%b unf=%b, expected upc=%h sp=%0d halted=%b ovf=%b unf=%b",
                  name, upc, sp, halted, stack_ovf, stack_unf, e_upc, e_sp, e_h, e_o, e_u);
      end
   endtask

   initial begin
      rst = 1'b0; en = 1'b0; restart = 1'b0; op = OP_NEXT; cond_sel = 3'd0;
      cond_pol = 1'b0; jump_addr = 8'h00; map_addr = 8'h00; status = 8'h00;

      //          rs    en    op        sel   pol   ja     ma     st     upc    sp    h     o     u
      vecs.push_back(mk(1'b0, 1'b1, OP_NEXT,  3'd0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h01, 3'd0, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 1'b1, OP_NEXT,  3'd0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h02, 3'd0, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 1'b1, OP_NEXT,  3'd0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h03, 3'd0, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 1'b1, OP_JUMP,  3'd0, 1'b0, 8'hFF, 8'h00, 8'h00, 8'hFF, 3'd0, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 1'b1, OP_NEXT,  3'd0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 1'b1, OP_JUMP,  3'd0, 1'b0, 8'h30, 8'h00, 8'h00, 8'h30, 3'd0, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 1'b1, OP_CJUMP, 3'd3, 1'b0, 8'h40, 8'h00, 8'h08, 8'h40, 3'd0, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 1'b1, OP_CJUMP, 3'd3, 1'b1, 8'h50, 8'h00, 8'h08, 8'h41, 3'd0, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 1'b1, OP_CJUMP, 3'd2, 1'b1, 8'h60, 8'h00, 8'h08, 8'h60, 3'd0, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 1'b1, OP_JUMP,  3'd0, 1'b0, 8'h05, 8'h00, 8'h00, 8'h05, 3'd0, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 1'b1, OP_CALL,  3'd0, 1'b0, 8'h10, 8'h00, 8'h00, 8'h10, 3'd1, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 1'b1, OP_CALL,  3'd0, 1'b0, 8'h20, 8'h00, 8'h00, 8'h20, 3'd2, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 1'b1, OP_RET,   3'd0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h11, 3'd1, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 1'b1, OP_RET,   3'd0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h06, 3'd0, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 1'b0, OP_NEXT,  3'd0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h06, 3'd0, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 1'b1, OP_MAP,   3'd0, 1'b0, 8'h00, 8'h6B, 8'h00, 8'h6B, 3'd0, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 1'b1, OP_FETCH, 3'd0, 1'b0, 8'h77, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 1'b1, OP_CALL,  3'd0, 1'b0, 8'h70, 8'h00, 8'h00, 8'h70, 3'd1, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 1'b1, OP_RET,   3'd0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h01, 3'd0, 1'b0, 1'b0, 1'b0));
      // fill the stack, then overflow and halt
      vecs.push_back(mk(1'b0, 1'b1, OP_CALL,  3'd0, 1'b0, 8'h80, 8'h00, 8'h00, 8'h80, 3'd1, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 1'b1, OP_CALL,  3'd0, 1'b0, 8'h81, 8'h00, 8'h00, 8'h81, 3'd2, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 1'b1, OP_CALL,  3'd0, 1'b0, 8'h82, 8'h00, 8'h00, 8'h82, 3'd3, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 1'b1, OP_CALL,  3'd0, 1'b0, 8'h83, 8'h00, 8'h00, 8'h83, 3'd4, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 1'b1, OP_CALL,  3'd0, 1'b0, 8'h90, 8'h00, 8'h00, 8'h83, 3'd4, 1'b1, 1'b1, 1'b0));
      vecs.push_back(mk(1'b0, 1'b1, OP_JUMP,  3'd0, 1'b0, 8'h55, 8'h00, 8'h00, 8'h83, 3'd4, 1'b1, 1'b1, 1'b0));
      vecs.push_back(mk(1'b0, 1'b1, OP_RET,   3'd0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h83, 3'd4, 1'b1, 1'b1, 1'b0));
      vecs.push_back(mk(1'b1, 1'b1, OP_JUMP,  3'd0, 1'b0, 8'h55, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0));
      // underflow
      vecs.push_back(mk(1'b0, 1'b1, OP_RET,   3'd0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, 1'b1));
      vecs.push_back(mk(1'b0, 1'b1, OP_NEXT,  3'd0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, 1'b1));
      vecs.push_back(mk(1'b1, 1'b0, OP_NEXT,  3'd0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0));
      // explicit halt op
      vecs.push_back(mk(1'b0, 1'b1, OP_NEXT,  3'd0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h01, 3'd0, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 1'b1, OP_HALT,  3'd0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h01, 3'd0, 1'b1, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 1'b1, OP_NEXT,  3'd0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h01, 3'd0, 1'b1, 1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 1'b1, OP_NEXT,  3'd0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 1'b1, OP_NEXT,  3'd0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h01, 3'd0, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 1'b1, OP_CJUMP, 3'd3, 1'b0, 8'h40, 8'h00, 8'h00, 8'h02, 3'd0, 1'b0, 1'b0, 1'b0));

      repeat (2) @(negedge clk);
      check("reset", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         restart   = vecs[i].rs;
         en        = vecs[i].en;
         op        = vecs[i].op;
         cond_sel  = vecs[i].sel;
         cond_pol  = vecs[i].pol;
         jump_addr = vecs[i].ja;
         map_addr  = vecs[i].ma;
         status    = vecs[i].st;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d", i), vecs[i].e_upc, vecs[i].e_sp,
               vecs[i].e_halt, vecs[i].e_ovf, vecs[i].e_unf);
      end

      // async reset asserted mid-cycle while a CALL is presented
      @(negedge clk);
      restart = 1'b0; en = 1'b1; op = OP_CALL; jump_addr = 8'h44;
      @(posedge clk);
      #1;
      check("call_before_rst", 8'h44, 3'd1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      jump_addr = 8'h45;
      #2;
      rst = 1'b0;
      #1;
      check("async_rst", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check("rst_held", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b1; en = 1'b1; op = OP_MAP; map_addr = 8'h6B;
      @(posedge clk);
      #1;
      check("map_after_rst", 8'h6B, 3'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      op = OP_NEXT;
      @(posedge clk);
      #1;
      check("next_after_map", 8'h6C, 3'd0, 1'b0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
